// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the framed serial deserializer.
// Frame layout: one start bit, data LSB first, optional parity, one stop bit.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // The idle line sits at 0, so a start bit is a 1 and the stop bit returns the line to 0.
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // The counter is sized for the widest supported word, so it suits every DATA_W.
    localparam int MAX_DATA_W = 32;
    localparam int CNT_W      = $clog2(MAX_DATA_W + 1);

    // Returns the parity bit the sender should have sent for the given XOR of the data bits.
    function automatic logic parity_expected(input logic data_xor, input logic odd);
        return data_xor ^ odd;
    endfunction

endpackage

// File: rtl/deser_out_slot.sv
// One-entry output holding register with a valid/ready handshake.
// If a new word arrives while the slot is full and is not being drained, the new word is dropped and overrun pulses.
module deser_out_slot
    import serial_frame_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              overrun
);

    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              overrun_r;
    logic              accept_s;

    assign accept_s = valid_r & m_ready;

    // Load, drain, or drop. A word that arrives in the same cycle as a drain replaces the held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r    <= {DATA_W{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (load) begin
                if (!valid_r || accept_s) begin
                    data_r  <= load_data;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (accept_s) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign m_data  = data_r;
    assign m_valid = valid_r;
    assign overrun = overrun_r;

endmodule

// File: rtl/serial_frame_deser.sv
// Framed serial receiver: samples serial_in on bit_en and detects start, data, parity and stop bits.
// A good word is handed to a one-entry valid/ready slot; a bad frame is dropped and flagged with a one-cycle pulse.
module serial_frame_deser
    import serial_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic [DATA_W-1:0] shift_r, shift_nx_s, shift_in_s;
    logic              par_acc_r, par_acc_nx_s;
    logic              par_bad_r, par_bad_nx_s;
    logic              frame_err_r, parity_err_r;
    logic              frame_good_s, frame_bad_s, par_bad_evt_s;

    // Each new bit enters at the MSB and moves down, so after DATA_W bits the first bit sits at index 0.
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign shift_in_s = serial_in;
        end else begin : g_shift_many
            assign shift_in_s = {serial_in, shift_r[DATA_W-1:1]};
        end
    endgenerate

    // Next-state, datapath updates and frame verdicts; nothing moves unless bit_en is high.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        shift_nx_s    = shift_r;
        par_acc_nx_s  = par_acc_r;
        par_bad_nx_s  = par_bad_r;
        frame_good_s  = 1'b0;
        frame_bad_s   = 1'b0;
        par_bad_evt_s = 1'b0;
        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    if (serial_in == START_BIT) begin
                        state_nx_s   = DATA;
                        cnt_nx_s     = {CNT_W{1'b0}};
                        par_acc_nx_s = 1'b0;
                        par_bad_nx_s = 1'b0;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                DATA: begin
                    shift_nx_s   = shift_in_s;
                    par_acc_nx_s = par_acc_r ^ serial_in;
                    cnt_nx_s     = cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        if (PARITY_EN) begin
                            state_nx_s = PARITY;
                        end else begin
                            state_nx_s = STOP;
                        end
                    end else begin
                        state_nx_s = DATA;
                    end
                end
                PARITY: begin
                    par_bad_nx_s = (serial_in != parity_expected(par_acc_r, PARITY_ODD));
                    state_nx_s   = STOP;
                end
                STOP: begin
                    state_nx_s = IDLE;
                    // A bad stop bit takes precedence over a parity mismatch.
                    if (serial_in == STOP_BIT) begin
                        if (!par_bad_r) begin
                            frame_good_s = 1'b1;
                        end else begin
                            par_bad_evt_s = 1'b1;
                        end
                    end else begin
                        frame_bad_s = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM state, shift register, counter, parity tracking and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            shift_r      <= {DATA_W{1'b0}};
            par_acc_r    <= 1'b0;
            par_bad_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            shift_r      <= shift_nx_s;
            par_acc_r    <= par_acc_nx_s;
            par_bad_r    <= par_bad_nx_s;
            frame_err_r  <= frame_bad_s;
            parity_err_r <= par_bad_evt_s;
        end
    end

    deser_out_slot #(
        .DATA_W (DATA_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (frame_good_s),
        .load_data (shift_r),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .overrun   (overrun)
    );

    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser (DATA_W=8, even parity).
// Frames are built from hand-chosen words; a small 4-bit SISO model feeds the line for the end-to-end case.
module tb_serial_frame_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_s;
    logic       bit_en;
    logic       m_ready;
    logic       use_siso;
    logic [3:0] siso_r;
    logic       serial_s;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // SISO shift register feeding the receiver in the end-to-end case.
    always_ff @(posedge clk) begin
        if (rst) begin
            siso_r <= 4'b0000;
        end else if (bit_en) begin
            siso_r <= {siso_r[2:0], line_s};
        end
    end

    assign serial_s = use_siso ? siso_r[3] : line_s;

    serial_frame_deser #(
        .DATA_W     (8),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_s),
        .bit_en     (bit_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic tick(input logic b, input logic en);
        line_s = b;
        bit_en = en;
        @(posedge clk);
        #1;
    endtask

    // Sends start, d LSB first, even parity (optionally flipped), stop. Returns just after the stop-sample edge.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b,
                              input logic rdy_stop, input logic gaps, output logic busy_low);
        logic [10:0] bits;
        busy_low = 1'b0;
        bits = {stop_b, (^d) ^ par_flip, d, 1'b1};
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && rdy_stop) m_ready = 1'b1;
            tick(bits[i], 1'b1);
            if (gaps && i < 10) begin
                repeat (2) begin
                    tick(bits[i], 1'b0);
                    if (busy !== 1'b1) busy_low = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; line_s = 1'b0; bit_en = 1'b0; m_ready = 1'b0; use_siso = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL reset_slot: got valid=%b data=%h, want 0/00", m_valid, m_data); end
        checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b fe=%b pe=%b ov=%b, want all 0", busy, frame_err, parity_err, overrun); end
    endtask

    task automatic test_good_frame();
        logic bl;
        m_ready = 1'b1;
        tick(1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, bl);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin errors++; $display("FAIL good_a5: got valid=%b data=%h, want 1/a5", m_valid, m_data); end
        checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL good_a5_errs: got fe=%b pe=%b ov=%b, want 0", frame_err, parity_err, overrun); end
        tick(1'b0, 1'b1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL good_a5_one_cycle: got valid=%b, want 0", m_valid); end
    endtask

    task automatic test_errors();
        logic bl;
        m_ready = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, bl);
        checks++; if (parity_err !== 1'b1 || frame_err !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL parity_bad: got pe=%b fe=%b valid=%b, want 1/0/0", parity_err, frame_err, m_valid); end
        tick(1'b0, 1'b1);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_pulse: got pe=%b, want 0", parity_err); end
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, bl);
        checks++; if (frame_err !== 1'b1 || parity_err !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL stop_bad: got fe=%b pe=%b valid=%b, want 1/0/0", frame_err, parity_err, m_valid); end
        tick(1'b0, 1'b1);
        checks++; if (frame_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_bad_idle: got fe=%b busy=%b, want 0/0", frame_err, busy); end
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, bl);
        checks++; if (frame_err !== 1'b1 || parity_err !== 1'b0) begin errors++; $display("FAIL both_bad: got fe=%b pe=%b, want 1/0", frame_err, parity_err); end
        tick(1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        logic bl;
        m_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, bl);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin errors++; $display("FAIL ovr_first: got valid=%b data=%h, want 1/11", m_valid, m_data); end
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, bl);
        checks++; if (overrun !== 1'b1 || m_data !== 8'h11 || m_valid !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got ov=%b data=%h valid=%b, want 1/11/1", overrun, m_data, m_valid); end
        tick(1'b0, 1'b1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle: got ov=%b, want 0", overrun); end
        m_ready = 1'b1;
        tick(1'b0, 1'b1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got valid=%b, want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic bl;
        m_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, bl);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, bl);
        checks++; if (overrun !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h22) begin errors++; $display("FAIL same_cycle: got ov=%b valid=%b data=%h, want 0/1/22", overrun, m_valid, m_data); end
        tick(1'b0, 1'b1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL same_cycle_drain: got valid=%b, want 0", m_valid); end
    endtask

    task automatic test_bit_en_gaps();
        logic bl;
        m_ready = 1'b0;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, bl);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hF0) begin errors++; $display("FAIL gaps_data: got valid=%b data=%h, want 1/f0", m_valid, m_data); end
        checks++; if (bl !== 1'b0) begin errors++; $display("FAIL gaps_busy: got busy_dropped=%b, want 0", bl); end
    endtask

    task automatic test_reset_midframe();
        logic bl;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1); tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got busy=%b, want 1", busy); end
        rst = 1'b1;
        tick(1'b0, 1'b1);
        rst = 1'b0;
        checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: got valid=%b data=%h busy=%b, want 0/00/0", m_valid, m_data, busy); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, bl);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A || overrun !== 1'b0) begin errors++; $display("FAIL after_reset: got valid=%b data=%h ov=%b, want 1/5a/0", m_valid, m_data, overrun); end
        m_ready = 1'b1;
        tick(1'b0, 1'b1);
    endtask

    task automatic test_siso_e2e();
        logic bl;
        m_ready = 1'b1;
        repeat (4) tick(1'b0, 1'b1);
        use_siso = 1'b1;
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, bl);
        repeat (4) tick(1'b0, 1'b1);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h96) begin errors++; $display("FAIL siso_96: got valid=%b data=%h, want 1/96", m_valid, m_data); end
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, bl);
        repeat (4) tick(1'b0, 1'b1);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h01 || parity_err !== 1'b0) begin errors++; $display("FAIL siso_01: got valid=%b data=%h pe=%b, want 1/01/0", m_valid, m_data, parity_err); end
        tick(1'b0, 1'b1);
        use_siso = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_errors();
        test_overrun();
        test_back_to_back();
        test_bit_en_gaps();
        test_reset_midframe();
        test_siso_e2e();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
